// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Program counter and single-outstanding imem fetch front end with
//            one-entry decode buffer and EX-driven redirect/flush.
//            Optional FETCH_PERF_CNT_EN adds redirect/discard counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic        ex_bcomp,
  input  logic [31:0] ex_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        flush,
  output logic        misalign
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_discards
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] issued_q, issued_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;
  logic        redirect;
  logic        buf_free;

  always_comb begin
    redirect   = ex_valid && (ex_is_jump || (ex_is_branch && ex_bcomp));
    buf_free   = !if_valid_q || if_ready;
    state_d    = state_q;
    pc_d       = pc_q;
    issued_d   = issued_q;
    if_valid_d = if_valid_q && !if_ready;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    flush_d    = redirect;
    misalign_d = redirect && (ex_target[1:0] != 2'b00);
    imem_req   = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        imem_req = buf_free;
        if (buf_free && imem_gnt) begin
          issued_d = pc_q;
          state_d  = redirect ? ST_DISCARD : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_d = ST_REQ;
          if (!redirect) begin
            if_instr_d = imem_rdata;
            if_pc_d    = issued_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'(PC_STEP);
          end
        end else if (redirect) begin
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (imem_rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect overrides both a decode consume and a same-cycle capture.
    if (redirect) begin
      pc_d       = {ex_target[31:2], 2'b00};
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      issued_q   <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'h0;
      if_pc_q    <= 32'h0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      issued_q   <= issued_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign flush     = flush_q;
  assign misalign  = misalign_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects_q, perf_redirects_d;
  logic [31:0] perf_discards_q, perf_discards_d;
  logic        drop;

  // A response is dropped if it lands in DISCARD or collides with a redirect in WAIT.
  always_comb begin
    drop = imem_rvalid &&
           ((state_q == ST_DISCARD) || ((state_q == ST_WAIT) && redirect));
    perf_redirects_d = perf_redirects_q + {31'b0, redirect};
    perf_discards_d  = perf_discards_q + {31'b0, drop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_redirects_q <= 32'h0;
      perf_discards_q  <= 32'h0;
    end else begin
      perf_redirects_q <= perf_redirects_d;
      perf_discards_q  <= perf_discards_d;
    end
  end

  assign perf_redirects = perf_redirects_q;
  assign perf_discards  = perf_discards_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Self-checking bench for pc_fetch_unit: directed vector table,
//            async-reset corner case, then randomized run against a stream model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_is_jump = 1'b0, ex_bcomp = 1'b0;
  logic [31:0] ex_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        if_ready = 1'b0;
  logic        flush, misalign;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects, perf_discards;
`endif

  pc_fetch_unit dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_bcomp(ex_bcomp), .ex_target(ex_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .flush(flush), .misalign(misalign)
`ifdef FETCH_PERF_CNT_EN
    , .perf_redirects(perf_redirects), .perf_discards(perf_discards)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  typedef struct {
    logic [31:0] rdy, gnt, rv, rdata, exv, br, jmp, bc, tgt;
    logic [31:0] req, addr, ifv, ifpc, ifinstr, fl, mis;
  } vec_t;

  localparam logic [31:0] A0 = 32'h1111_0000, A4 = 32'h1111_0004, A8 = 32'h1111_0008;
  localparam logic [31:0] B0 = 32'h2222_0100, B4 = 32'h2222_0104, C0 = 32'h3333_0108;
  localparam logic [31:0] D0 = 32'h4444_0200, E0 = 32'h5555_0300;

  vec_t vt[25];

  // Random-phase memory and stream model state
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  logic [31:0] exp_pc;
  bit          prev_redir, prev_mis, prev_req_nognt, redir;
  logic [31:0] prev_addr;
  int          consumes;
  int          pick;

  initial begin
    //            rdy gnt rv rdata  exv br jmp bc tgt      req addr   ifv ifpc    instr fl mis
    vt[0]  = '{1, 1, 0, 0,     0, 0, 0, 0, 0,        0, 0,     0, 0,     0,  0, 0};
    vt[1]  = '{1, 1, 0, 0,     0, 0, 0, 0, 0,        1, 0,     0, 0,     0,  0, 0};
    vt[2]  = '{1, 0, 1, A0,    0, 0, 0, 0, 0,        0, 0,     0, 0,     0,  0, 0};
    vt[3]  = '{1, 1, 0, 0,     0, 0, 0, 0, 0,        1, 'h4,   1, 0,     A0, 0, 0};
    vt[4]  = '{1, 0, 1, A4,    0, 0, 0, 0, 0,        0, 'h4,   0, 0,     A0, 0, 0};
    vt[5]  = '{1, 1, 0, 0,     0, 0, 0, 0, 0,        1, 'h8,   1, 'h4,   A4, 0, 0};
    vt[6]  = '{1, 0, 0, 0,     1, 1, 0, 1, 'h100,    0, 'h8,   0, 'h4,   A4, 0, 0};
    vt[7]  = '{1, 0, 1, A8,    0, 0, 0, 0, 0,        0, 'h100, 0, 'h4,   A4, 1, 0};
    vt[8]  = '{1, 1, 0, 0,     0, 0, 0, 0, 0,        1, 'h100, 0, 'h4,   A4, 0, 0};
    vt[9]  = '{1, 0, 1, B0,    0, 0, 0, 0, 0,        0, 'h100, 0, 'h4,   A4, 0, 0};
    vt[10] = '{0, 1, 0, 0,     1, 1, 0, 0, 'h80,     0, 'h104, 1, 'h100, B0, 0, 0};
    vt[11] = '{0, 1, 0, 0,     0, 0, 0, 0, 0,        0, 'h104, 1, 'h100, B0, 0, 0};
    vt[12] = '{1, 1, 0, 0,     0, 0, 0, 0, 0,        1, 'h104, 1, 'h100, B0, 0, 0};
    vt[13] = '{1, 0, 1, B4,    0, 0, 0, 0, 0,        0, 'h104, 0, 'h100, B0, 0, 0};
    vt[14] = '{1, 1, 0, 0,     1, 0, 1, 0, 'h203,    1, 'h108, 1, 'h104, B4, 0, 0};
    vt[15] = '{1, 1, 0, 0,     0, 0, 0, 0, 0,        0, 'h200, 0, 'h104, B4, 1, 1};
    vt[16] = '{1, 0, 1, C0,    0, 0, 0, 0, 0,        0, 'h200, 0, 'h104, B4, 0, 0};
    vt[17] = '{1, 1, 0, 0,     0, 0, 0, 0, 0,        1, 'h200, 0, 'h104, B4, 0, 0};
    vt[18] = '{1, 0, 1, D0,    0, 0, 0, 0, 0,        0, 'h200, 0, 'h104, B4, 0, 0};
    vt[19] = '{1, 0, 0, 0,     0, 0, 0, 0, 0,        1, 'h204, 1, 'h200, D0, 0, 0};
    vt[20] = '{1, 0, 0, 0,     1, 0, 1, 1, 'h300,    1, 'h204, 0, 'h200, D0, 0, 0};
    vt[21] = '{1, 1, 0, 0,     0, 0, 0, 0, 0,        1, 'h300, 0, 'h200, D0, 1, 0};
    vt[22] = '{1, 0, 1, E0,    1, 0, 1, 0, 'h400,    0, 'h300, 0, 'h200, D0, 0, 0};
    vt[23] = '{1, 0, 0, 0,     0, 1, 1, 1, 'h500,    1, 'h400, 0, 'h200, D0, 1, 0};
    vt[24] = '{1, 0, 0, 0,     0, 0, 0, 0, 0,        1, 'h400, 0, 'h200, D0, 0, 0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("reset imem_req", imem_req, 1'b0);
    check32("reset imem_addr", imem_addr, 32'h0);
    check1("reset if_valid", if_valid, 1'b0);
    check32("reset if_instr", if_instr, 32'h0);
    check32("reset if_pc", if_pc, 32'h0);
    check1("reset flush", flush, 1'b0);
    check1("reset misalign", misalign, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vector table, one row per cycle
    for (int i = 0; i < 25; i++) begin
      if_ready     = vt[i].rdy[0];
      imem_gnt     = vt[i].gnt[0];
      imem_rvalid  = vt[i].rv[0];
      imem_rdata   = vt[i].rdata;
      ex_valid     = vt[i].exv[0];
      ex_is_branch = vt[i].br[0];
      ex_is_jump   = vt[i].jmp[0];
      ex_bcomp     = vt[i].bc[0];
      ex_target    = vt[i].tgt;
      @(negedge clk);
      check1($sformatf("row%0d imem_req", i), imem_req, vt[i].req[0]);
      check32($sformatf("row%0d imem_addr", i), imem_addr, vt[i].addr);
      check1($sformatf("row%0d if_valid", i), if_valid, vt[i].ifv[0]);
      check32($sformatf("row%0d if_pc", i), if_pc, vt[i].ifpc);
      check32($sformatf("row%0d if_instr", i), if_instr, vt[i].ifinstr);
      check1($sformatf("row%0d flush", i), flush, vt[i].fl[0]);
      check1($sformatf("row%0d misalign", i), misalign, vt[i].mis[0]);
      @(posedge clk); #1;
    end
`ifdef FETCH_PERF_CNT_EN
    check32("perf_redirects", perf_redirects, 32'd4);
    check32("perf_discards", perf_discards, 32'd3);
`endif

    // Asynchronous reset while a fetch is outstanding; late response must be ignored
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_bcomp = 1'b0;
    imem_rvalid = 1'b0; if_ready = 1'b1; imem_gnt = 1'b1;
    @(negedge clk);
    check1("pre-reset req", imem_req, 1'b1);
    @(posedge clk); #1;
    imem_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    check32("async reset imem_addr", imem_addr, 32'h0);
    check1("async reset imem_req", imem_req, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check32("reset perf_redirects", perf_redirects, 32'd0);
    check32("reset perf_discards", perf_discards, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    check1("late rvalid idle req", imem_req, 1'b0);
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    @(negedge clk);
    check1("late rvalid if_valid", if_valid, 1'b0);
    check1("post-reset req", imem_req, 1'b1);
    check32("post-reset addr", imem_addr, 32'h0);
    @(posedge clk); #1;

    // Randomized run against an instruction-stream model
    pend = 0; pend_cnt = 0; pend_addr = 0;
    exp_pc = 32'h0; prev_redir = 0; prev_mis = 0; prev_req_nognt = 0;
    prev_addr = 0; consumes = 0;
    for (int n = 0; n < 4000; n++) begin
      if_ready     = ($urandom % 4) != 0;
      imem_gnt     = ($urandom % 3) != 0;
      ex_valid     = ($urandom % 10) == 0;
      ex_is_branch = $urandom % 2 == 1;
      ex_is_jump   = ($urandom % 3) == 0;
      ex_bcomp     = $urandom % 2 == 1;
      pick = int'($urandom % 4);
      if (pick == 0)      ex_target = 32'hFFFF_FFF0 + ($urandom % 16);
      else if (pick == 1) ex_target = 32'h0000_1000 + ($urandom % 1024);
      else                ex_target = $urandom;
      if (pend && pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 0;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend) pend_cnt--;
      end

      @(negedge clk);
      redir = ex_valid && (ex_is_jump || (ex_is_branch && ex_bcomp));
      check1("rand flush", flush, prev_redir);
      check1("rand misalign", misalign, prev_mis);
      if (prev_redir) check1("rand if_valid after redirect", if_valid, 1'b0);
      if (imem_req && prev_req_nognt && !prev_redir)
        check32("rand addr stable", imem_addr, prev_addr);
      if (if_valid && if_ready && !redir) begin
        check32("rand if_pc", if_pc, exp_pc);
        check32("rand if_instr", if_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumes++;
      end
      if (redir) exp_pc = {ex_target[31:2], 2'b00};
      if (imem_req && imem_gnt) begin
        check1("rand one outstanding", pend, 1'b0);
        pend      = 1;
        pend_cnt  = int'($urandom_range(0, 2));
        pend_addr = imem_addr;
      end
      prev_req_nognt = imem_req && !imem_gnt;
      prev_addr      = imem_addr;
      prev_redir     = redir;
      prev_mis       = redir && (ex_target[1:0] != 2'b00);
      @(posedge clk); #1;
    end
    checks++;
    if (consumes < 100) begin
      errors++;
      $display("FAIL rand progress: got %0d consumed, expected at least 100", consumes);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
